// File: rtl/feature_serializer.sv
// Ping-pong serializer: buffers up to two feature vectors and streams them one feature per cycle.
// Optional drop counter port enabled by defining FEATURE_SER_DROP_CNT_EN.
module feature_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VEC_DIM    = 18,
  parameter int unsigned IDX_W      = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH*VEC_DIM-1:0] in_vector,
  input  logic                          in_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          overflow
`ifdef FEATURE_SER_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_count
`endif
);

  localparam int unsigned VecW = DATA_WIDTH * VEC_DIM;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(VEC_DIM - 1);

  logic [VecW-1:0]       slot_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic [IDX_W-1:0]      elem_q, elem_d;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] feat [VEC_DIM];

  logic xfer, release_vec, accept, drop;

  always_comb begin
    xfer        = out_valid & out_ready;
    release_vec = xfer & (elem_q == LastIdx);
    // A releasing slot can be refilled on the same edge it is freed.
    accept      = in_valid & ((occ_q != 2'd2) | release_vec);
    drop        = in_valid & ~accept;

    occ_d = occ_q;
    unique case ({accept, release_vec})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    elem_d = elem_q;
    if (release_vec) begin
      elem_d = '0;
    end else if (xfer) begin
      elem_d = elem_q + IDX_W'(1);
    end

    rd_ptr_d = rd_ptr_q ^ release_vec;
    wr_ptr_d = wr_ptr_q ^ accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      elem_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        slot_q[wr_ptr_q] <= in_vector;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      elem_q     <= elem_d;
      overflow_q <= drop;
    end
  end

`ifdef FEATURE_SER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  always_comb begin
    for (int k = 0; k < VEC_DIM; k++) begin
      feat[k] = slot_q[rd_ptr_q][k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = feat[elem_q];
  assign out_idx   = elem_q;
  assign out_last  = out_valid & (elem_q == LastIdx);
  assign busy      = out_valid;
  assign overflow  = overflow_q;

endmodule
